ex_muldiv_unit: RTL and testbench

- Execute-stage HI/LO multiply/divide unit. Sits directly downstream of the ID/EX pipeline register.
- Consumes the latched operands (rs/rt read data) plus a decoded mul/div opcode and start strobe. Runs an iterative 32-cycle shift-add multiply or restoring divide.
- Owns the architectural HI/LO registers. Raises a stall to the hazard logic while MFHI/MFLO/MTHI/MTLO or a new mul/div collides with an in-flight operation.

---
 rtl/ex_muldiv_unit_if.sv | 48 ++++
 rtl/ex_muldiv_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - ID/EX to HI/LO multiply/divide unit handshake bundle
//
// Purpose: groups the decoded mul/div request, HI/LO move controls and the
// unit's status/result outputs into one bundle.
// Signals:
//   i_start    ID/EX holds a valid mul/div instruction
//   i_op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_rs_data  operand A (multiplicand / dividend)
//   i_rt_data  operand B (multiplier / divisor)
//   i_hilo_rd  ID/EX holds MFHI or MFLO
//   i_hilo_wr  bit1 MTHI, bit0 MTLO
//   i_wdata    MTHI/MTLO source data
//   i_flush    squash the in-flight operation
//   o_busy     operation in flight
//   o_stall    freeze PC, IF/ID and ID/EX
//   o_done     one-cycle pulse when HI/LO update from an operation
//   o_hi/o_lo  architectural HI/LO registers
// Modports: master (pipeline side), slave (the unit).

interface ex_muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              i_start;
    logic [1:0]        i_op;
    logic [DATA_W-1:0] i_rs_data;
    logic [DATA_W-1:0] i_rt_data;
    logic              i_hilo_rd;
    logic [1:0]        i_hilo_wr;
    logic [DATA_W-1:0] i_wdata;
    logic              i_flush;
    logic              o_busy;
    logic              o_stall;
    logic              o_done;
    logic [DATA_W-1:0] o_hi;
    logic [DATA_W-1:0] o_lo;

    modport master (
        output i_start, i_op, i_rs_data, i_rt_data, i_hilo_rd,
               i_hilo_wr, i_wdata, i_flush,
        input  o_busy, o_stall, o_done, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_rs_data, i_rt_data, i_hilo_rd,
               i_hilo_wr, i_wdata, i_flush,
        output o_busy, o_stall, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - execute-stage iterative HI/LO multiply/divide unit
//
// Purpose: owns HI/LO, runs a 32-iteration shift-add multiply or restoring
// divide (IDLE -> CALC -> FIX -> IDLE), performs MTHI/MTLO writes in IDLE and
// stalls the front of the pipeline when a HI/LO access or a new mul/div
// collides with an operation in flight.
// Ports:
//   i_clk    pipeline clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      ex_muldiv_unit_if.slave (request, HI/LO moves, busy/stall/done, HI/LO)
// Optional feature macro: MULDIV_EARLY_OUT_EN (multiply early termination
// once the remaining multiplier bits are zero; adds a 64-bit barrel shifter).

module ex_muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    ex_muldiv_unit_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                div_q, div_d;          // 1: divide, 0: multiply
    logic                neg_q, neg_d;          // product / quotient sign
    logic                rem_neg_q, rem_neg_d;  // remainder sign
    logic [DATA_W-1:0]   acc_q, acc_d;          // product high half / remainder
    logic [DATA_W-1:0]   mplier_q, mplier_d;    // multiplier+product low / dividend+quotient
    logic [DATA_W-1:0]   mcand_q, mcand_d;      // multiplicand / divisor
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done;

    // Operand conditioning for a new request
    logic                op_signed;
    logic                op_div;
    logic                div_zero;
    logic                use_abs;
    logic [DATA_W-1:0]   a_abs;
    logic [DATA_W-1:0]   b_abs;

    assign op_signed = ~bus.i_op[0];
    assign op_div    = bus.i_op[1];
    assign div_zero  = op_div & (bus.i_rt_data == '0);
    // A zero divisor keeps the raw dividend and no sign fix, so the restoring
    // loop naturally yields quotient all-ones and remainder = original A.
    assign use_abs   = op_signed & ~div_zero;
    assign a_abs     = (use_abs & bus.i_rs_data[DATA_W-1]) ? -bus.i_rs_data : bus.i_rs_data;
    assign b_abs     = (use_abs & bus.i_rt_data[DATA_W-1]) ? -bus.i_rt_data : bus.i_rt_data;

    // Multiply step: conditional add with carry kept in a 33-bit sum
    logic [DATA_W:0]     mul_sum;
    assign mul_sum = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(DATA_W+1){1'b0}});

    // Divide step: shift next dividend bit into the remainder, trial subtract.
    // The partial remainder is always below the divisor, so a successful
    // subtract leaves a result that fits in DATA_W bits; either of the two
    // upper bits set means the trial borrowed.
    logic [DATA_W:0]     div_shift;
    logic [DATA_W+1:0]   div_diff;
    logic                div_fits;
    assign div_shift = {acc_q, mplier_q[DATA_W-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
    assign div_fits  = (div_diff[DATA_W+1:DATA_W] == 2'b00);

    // Sign correction applied in FIX
    logic [2*DATA_W-1:0] product;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    assign product  = {acc_q, mplier_q};
    assign prod_fix = neg_q ? -product : product;
    assign quo_fix  = neg_q ? -mplier_q : mplier_q;
    assign rem_fix  = rem_neg_q ? -acc_q : acc_q;

`ifdef MULDIV_EARLY_OUT_EN
    // Bits of the original multiplier still to be consumed after this step
    // sit in mplier_q[cnt_q-1:1]; if all are zero, the remaining iterations
    // would only shift, so do the whole shift at once.
    logic [DATA_W-1:0]   rest_mask;
    logic                rest_zero;
    logic [2*DATA_W-1:0] mul_pair_next;
    logic [2*DATA_W-1:0] mul_pair_align;
    assign rest_mask      = (DATA_W'(1) << (cnt_q - CNT_W'(1))) - DATA_W'(1);
    assign rest_zero      = ((mplier_q >> 1) & rest_mask) == '0;
    assign mul_pair_next  = {mul_sum, mplier_q[DATA_W-1:1]};
    assign mul_pair_align = mul_pair_next >> (cnt_q - CNT_W'(1));
`endif

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.i_flush) begin
                    if (bus.i_start) begin
                        div_d     = op_div;
                        neg_d     = use_abs & (bus.i_rs_data[DATA_W-1] ^ bus.i_rt_data[DATA_W-1]);
                        rem_neg_d = use_abs & bus.i_rs_data[DATA_W-1];
                        mcand_d   = op_div ? b_abs : a_abs;
                        mplier_d  = op_div ? a_abs : b_abs;
                        acc_d     = '0;
                        cnt_d     = CNT_W'(DATA_W);
                        state_d   = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                        if (!op_div && (b_abs == '0)) begin
                            state_d = S_FIX;
                        end
`endif
                    end else if (bus.i_hilo_wr != 2'b00) begin
                        if (bus.i_hilo_wr[1]) hi_d = bus.i_wdata;
                        if (bus.i_hilo_wr[0]) lo_d = bus.i_wdata;
                    end
                end
            end

            S_CALC: begin
                if (bus.i_flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIX;
                    end
                    if (div_q) begin
                        if (div_fits) begin
                            acc_d    = div_diff[DATA_W-1:0];
                            mplier_d = {mplier_q[DATA_W-2:0], 1'b1};
                        end else begin
                            acc_d    = div_shift[DATA_W-1:0];
                            mplier_d = {mplier_q[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        acc_d    = mul_sum[DATA_W:1];
                        mplier_d = {mul_sum[0], mplier_q[DATA_W-1:1]};
`ifdef MULDIV_EARLY_OUT_EN
                        if (rest_zero) begin
                            {acc_d, mplier_d} = mul_pair_align;
                            state_d           = S_FIX;
                        end
`endif
                    end
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.i_flush) begin
                    done = 1'b1;
                    if (div_q) begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            acc_q     <= '0;
            mplier_q  <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            div_q     <= div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.o_busy  = (state_q != S_IDLE);
    assign bus.o_stall = bus.o_busy & (bus.i_start | bus.i_hilo_rd | (bus.i_hilo_wr != 2'b00));
    assign bus.o_done  = done;
    assign bus.o_hi    = hi_q;
    assign bus.o_lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit

module tb_ex_muldiv_unit;

    logic clk;
    logic rst_n;

    ex_muldiv_unit_if bus ();

    ex_muldiv_unit dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_start   = 1'b0;
        bus.i_op      = 2'b00;
        bus.i_rs_data = '0;
        bus.i_rt_data = '0;
        bus.i_hilo_rd = 1'b0;
        bus.i_hilo_wr = 2'b00;
        bus.i_wdata   = '0;
        bus.i_flush   = 1'b0;
    endtask

    // Called at posedge+1. Returns the number of edges after the accepting
    // edge until o_done is seen, and how many sampled cycles showed o_done.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output int lat, output int done_cnt);
        bus.i_start   = 1'b1;
        bus.i_op      = op;
        bus.i_rs_data = a;
        bus.i_rt_data = b;
        @(posedge clk); #1;
        bus.i_start   = 1'b0;
        lat      = 0;
        done_cnt = 0;
        while (!bus.o_done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.o_done) done_cnt++;
        @(posedge clk); #1;
        if (bus.o_done) done_cnt++;
        hi = bus.o_hi;
        lo = bus.o_lo;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] hi, lo;
        int lat, done_cnt, busy_n, stall_n, done_seen;

        vecs[0]  = '{"mult_m3x5",      2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{"multu_max",      2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{"mult_6x7",       2'b00, 32'd6,        32'd7,        32'h00000000, 32'd42};
        vecs[3]  = '{"mult_min_x2",    2'b00, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000};
        vecs[4]  = '{"multu_shift",    2'b01, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};
        vecs[5]  = '{"mult_m1xm1",     2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[6]  = '{"divu_100_7",     2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[7]  = '{"div_m7_2",       2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[8]  = '{"div_7_m2",       2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{"div_overflow",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[10] = '{"divu_by_zero",   2'b11, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
        vecs[11] = '{"div_neg_by_zero",2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[12] = '{"divu_max_1",     2'b11, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};

        // Reset state, with requests present that must not stall
        idle_inputs();
        rst_n = 1'b0;
        bus.i_start   = 1'b1;
        bus.i_hilo_rd = 1'b1;
        #3;
        check("reset_hi",    bus.o_hi,    32'h0);
        check("reset_lo",    bus.o_lo,    32'h0);
        check("reset_busy",  bus.o_busy,  1'b0);
        check("reset_stall", bus.o_stall, 1'b0);
        check("reset_done",  bus.o_done,  1'b0);
        idle_inputs();
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, lat, done_cnt);
            check({vecs[i].name, "_hi"},      hi,       vecs[i].hi);
            check({vecs[i].name, "_lo"},      lo,       vecs[i].lo);
            check({vecs[i].name, "_latency"}, lat,      32);
            check({vecs[i].name, "_done"},    done_cnt, 1);
            check({vecs[i].name, "_idle"},    bus.o_busy, 1'b0);
        end

        // MULTU max with MFHI/MFLO waiting from the second cycle
        bus.i_start   = 1'b1;
        bus.i_op      = 2'b01;
        bus.i_rs_data = 32'hFFFFFFFF;
        bus.i_rt_data = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.i_start   = 1'b0;
        bus.i_hilo_rd = 1'b1;
        busy_n  = 0;
        stall_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_busy)  busy_n++;
            if (bus.o_stall) stall_n++;
            if (i < 32) begin
                @(posedge clk); #1;
            end else begin
                break;
            end
        end
        @(posedge clk); #1;
        check("stall_busy_cycles",  busy_n,  33);
        check("stall_stall_cycles", stall_n, 33);
        check("stall_released",     bus.o_stall, 1'b0);
        check("stall_hi",           bus.o_hi, 32'hFFFFFFFE);
        check("stall_lo",           bus.o_lo, 32'h00000001);
        bus.i_hilo_rd = 1'b0;

        // MTHI in IDLE
        bus.i_hilo_wr = 2'b10;
        bus.i_wdata   = 32'hA5A5A5A5;
        @(posedge clk); #1;
        bus.i_hilo_wr = 2'b00;
        check("mthi_hi", bus.o_hi, 32'hA5A5A5A5);
        check("mthi_lo", bus.o_lo, 32'h00000001);

        // Flush in IDLE suppresses both start and MTLO
        bus.i_flush   = 1'b1;
        bus.i_start   = 1'b1;
        bus.i_op      = 2'b10;
        bus.i_hilo_wr = 2'b01;
        bus.i_wdata   = 32'hDEADBEEF;
        @(posedge clk); #1;
        idle_inputs();
        check("idle_flush_busy", bus.o_busy, 1'b0);
        check("idle_flush_lo",   bus.o_lo,   32'h00000001);

        // DIV flushed at CALC cycle 10
        bus.i_start   = 1'b1;
        bus.i_op      = 2'b10;
        bus.i_rs_data = 32'd100;
        bus.i_rt_data = 32'd7;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        done_seen = 0;
        for (int i = 1; i < 10; i++) begin
            if (bus.o_done) done_seen++;
            @(posedge clk); #1;
        end
        check("flush_busy_before", bus.o_busy, 1'b1);
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        check("flush_busy_after", bus.o_busy, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (bus.o_done || bus.o_busy) done_seen++;
            @(posedge clk); #1;
        end
        check("flush_no_done", done_seen, 0);
        check("flush_hi", bus.o_hi, 32'hA5A5A5A5);
        check("flush_lo", bus.o_lo, 32'h00000001);

        // MTHI and MTLO together
        bus.i_hilo_wr = 2'b11;
        bus.i_wdata   = 32'h13579BDF;
        @(posedge clk); #1;
        bus.i_hilo_wr = 2'b00;
        check("mthilo_hi", bus.o_hi, 32'h13579BDF);
        check("mthilo_lo", bus.o_lo, 32'h13579BDF);

        // Asynchronous reset mid-CALC
        bus.i_start   = 1'b1;
        bus.i_op      = 2'b00;
        bus.i_rs_data = 32'd6;
        bus.i_rt_data = 32'd7;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        bus.i_hilo_rd = 1'b1;
        #1;
        check("arst_pre_stall", bus.o_stall, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",  bus.o_busy,  1'b0);
        check("arst_stall", bus.o_stall, 1'b0);
        check("arst_hi",    bus.o_hi,    32'h0);
        check("arst_lo",    bus.o_lo,    32'h0);
        bus.i_hilo_rd = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b00, 32'd6, 32'd7, hi, lo, lat, done_cnt);
        check("post_rst_hi",      hi,  32'h0);
        check("post_rst_lo",      lo,  32'd42);
        check("post_rst_latency", lat, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
